sp_array_fifo_ctrl: RTL and testbench
=====================================

Name: sp_array_fifo_ctrl

Overview:
- FIFO controller wrapping one external single-port 256x7 array macro (array_36_ext class: RW0 port, 1-cycle registered-address read, rdata valid only in the cycle after the read).
- Sits directly upstream of and around the array: converts an enq/deq valid/ready stream into RW0 commands.
- Uses one input staging register and a 2-entry output buffer to hide the single-port read latency.

Parameters:
- W, 7, data width; must match the array width.
- AW, 8, array address width.
- DEPTH, 256, array entries; equals 2^AW.

Ports:
- clock  in  1  rising-edge clock; also drives the array's RW0_clk.
- reset_n  in  1  asynchronous active-low reset.
- enq_valid  in  1  upstream data valid.
- enq_ready  out  1  controller can accept.
- enq_data  in  W  upstream data.
- deq_valid  out  1  output buffer head valid.
- deq_ready  in  1  downstream accepts.
- deq_data  out  W  output buffer head.
- count  out  AW+1  total held entries (wbuf + RAM + read in flight + obuf); maximum DEPTH+3, so the field is 9 bits at default parameters.
- mem_en  out  1  to RW0_en.
- mem_wmode  out  1  to RW0_wmode.
- mem_addr  out  AW  to RW0_addr.
- mem_wdata  out  W  to RW0_wdata.
- mem_rdata  in  W  from RW0_rdata.

Behaviour:
- Reset (async, reset_n=0):
  - wbuf_v, rd_pend, obuf_cnt, ram_cnt, wptr, rptr, rr_last all 0.
  - Outputs: enq_ready=1, deq_valid=0, deq_data=0, count=0, mem_en=0, mem_wmode=0.
  - Array contents are not cleared. Pointer reset makes stale data unreachable.
  - A read in flight when reset asserts is discarded.
- Registered state:
  - wbuf (1 entry, plus valid bit).
  - ram_cnt (0..DEPTH).
  - wptr, rptr (AW bits each; wrap DEPTH-1 -> 0).
  - rd_pend: read issued last cycle.
  - obuf: 2-entry queue.
  - rr_last: last arbitrated operation, 1 = read.
- Derived signals, all from registers only (no combinational path from deq_ready or enq_valid to mem_* or enq_ready):
  - obuf_space = (obuf_cnt + rd_pend) < 2.
  - rd_ok = ram_cnt>0 && obuf_space.
  - wr_ok = wbuf_v && ram_cnt<DEPTH.
  - byp_ok = wbuf_v && ram_cnt==0 && !rd_pend && obuf_cnt<2 (only when the optional feature is enabled).
- Per-cycle arbitration:
  - byp_ok: move wbuf to obuf tail; no memory operation.
  - Else rd_ok && wr_ok: round-robin. Read if rr_last==0, otherwise write.
  - Else rd_ok: read.
  - Else wr_ok: write.
  - Else idle: mem_en=0.
- Read:
  - mem_en=1, mem_wmode=0, mem_addr=rptr.
  - rptr++, ram_cnt--, rd_pend<=1, rr_last<=1.
- Write:
  - mem_en=1, mem_wmode=1, mem_addr=wptr, mem_wdata=wbuf.
  - wptr++, ram_cnt++, wbuf_v cleared, rr_last<=0.
- Read capture: in the cycle with rd_pend=1, mem_rdata is sampled into the obuf tail at the clock edge. The array's rdata is not relied on after that cycle.
- enq handshake:
  - enq_ready = !wbuf_v || wbuf leaves this cycle (write or bypass).
  - Fire when enq_valid && enq_ready: wbuf loads enq_data and wbuf_v<=1.
- deq handshake:
  - deq_valid = obuf_cnt>0; deq_data = obuf head.
  - Fire pops the head.
  - Push and pop in the same cycle keep obuf_cnt unchanged.
- Bypass and read capture are mutually exclusive because byp_ok requires !rd_pend.
- Ordering: strict FIFO. Bypass is legal only when RAM and pipeline are empty.
- Full: ram_cnt==DEPTH, wbuf_v=1, obuf full. Then enq_ready=0 and count=DEPTH+3.
- Latency from enq fire at cycle T, empty FIFO, deq_ready=1:
  - Without bypass: write at T+1, read at T+2, capture at end of T+3, deq_valid at T+4.
  - With bypass: deq_valid at T+2.
- Throughput: sustained 1 entry per 2 cycles through the RAM (single port). Bypass sustains 1 per cycle while the RAM is empty.

Optional Feature:
- SP_ARRAY_FIFO_BYPASS_EN defined: byp_ok path is present as above.
- Undefined: byp_ok is forced to 0. Every entry passes through the array; the min-latency and throughput figures above change accordingly.

Test Plan:
- Reset with enq_valid=1 held: enq_ready=1, deq_valid=0, count=0, mem_en=0. After release, one enq of 0x55 -> deq_data=0x55. deq_valid rises at T+2 (bypass on) or T+4 (bypass off).
- deq_ready=0; push 0..258 -> enq_ready drops after 259 accepted, count=259. mem_addr writes wrap 0xFF->0x00 never occur before the first read.
- Full FIFO, then deq_ready=1 while enq pushes continue -> deq order exactly 0,1,2,... with no drop or duplicate. Reads and writes alternate (round-robin) when both are eligible.
- 600 random values, random valid/ready, -> output sequence equals input sequence. Pointers wrap at least twice; count matches the scoreboard every cycle.
- Assert reset_n mid-stream while rd_pend=1 -> all state cleared immediately. A post-reset enq of 0x12 is the first value dequeued; no stale data appears.
- Bypass off, deq_ready=1, enq every cycle -> enq_ready duty cycle 50% in steady state. Never two consecutive mem_en cycles with the same wmode while both operations are eligible.

Source files
------------

// File: rtl/sp_array_fifo_ctrl.sv
// rtl/sp_array_fifo_ctrl.sv - FIFO controller around a single-port 256x7 array (optional bypass: SP_ARRAY_FIFO_BYPASS_EN)
module sp_array_fifo_ctrl #(
  parameter int W     = 7,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [W-1:0]  enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [W-1:0]  deq_data,
  output logic [AW:0]   count,
  output logic          mem_en,
  output logic          mem_wmode,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  wbuf;
  logic          wbuf_v;
  logic [AW:0]   ram_cnt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_pend;
  logic          rr_last;
  logic [W-1:0]  ob0;
  logic [W-1:0]  ob1;
  logic [1:0]    obuf_cnt;

  logic          obuf_space;
  logic          rd_ok;
  logic          wr_ok;
  logic          byp_ok;
  logic          do_rd;
  logic          do_wr;
  logic          do_byp;
  logic          enq_fire;
  logic          deq_fire;
  logic          push;
  logic [W-1:0]  push_data;

  // A read may only issue when its result is guaranteed a slot in obuf.
  assign obuf_space = ({1'b0, obuf_cnt} + {2'b00, rd_pend}) < 3'd2;
  assign rd_ok      = (ram_cnt != '0) && obuf_space;
  assign wr_ok      = wbuf_v && (ram_cnt != RAM_FULL);

`ifdef SP_ARRAY_FIFO_BYPASS_EN
  // Bypass only when nothing older sits in the RAM or the read pipeline.
  assign byp_ok = wbuf_v && (ram_cnt == '0) && !rd_pend && (obuf_cnt != 2'd2);
`else
  assign byp_ok = 1'b0;
`endif

  // Arbitrate the single array port; round-robin when both sides want it.
  always_comb begin
    do_byp = 1'b0;
    do_rd  = 1'b0;
    do_wr  = 1'b0;
    if (byp_ok) begin
      do_byp = 1'b1;
    end else if (rd_ok && wr_ok) begin
      do_rd = !rr_last;
      do_wr = rr_last;
    end else if (rd_ok) begin
      do_rd = 1'b1;
    end else if (wr_ok) begin
      do_wr = 1'b1;
    end
  end

  assign mem_en    = do_rd || do_wr;
  assign mem_wmode = do_wr;
  assign mem_addr  = do_wr ? wptr : rptr;
  assign mem_wdata = wbuf;

  assign enq_ready = !wbuf_v || do_wr || do_byp;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_valid = obuf_cnt != 2'd0;
  assign deq_data  = ob0;
  assign deq_fire  = deq_valid && deq_ready;

  // Bypass and read capture never coincide, so one push port suffices.
  assign push      = do_byp || rd_pend;
  assign push_data = do_byp ? wbuf : mem_rdata;

  assign count = ram_cnt + (AW+1)'(wbuf_v) + (AW+1)'(rd_pend) + (AW+1)'(obuf_cnt);

  // Staging register, RAM pointers/occupancy and arbitration history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbuf    <= '0;
      wbuf_v  <= 1'b0;
      ram_cnt <= '0;
      wptr    <= '0;
      rptr    <= '0;
      rd_pend <= 1'b0;
      rr_last <= 1'b0;
    end else begin
      if (enq_fire) begin
        wbuf   <= enq_data;
        wbuf_v <= 1'b1;
      end else if (do_wr || do_byp) begin
        wbuf_v <= 1'b0;
      end
      if (do_wr) begin
        wptr    <= wptr + 1'b1;
        ram_cnt <= ram_cnt + 1'b1;
        rr_last <= 1'b0;
      end else if (do_rd) begin
        rptr    <= rptr + 1'b1;
        ram_cnt <= ram_cnt - 1'b1;
        rr_last <= 1'b1;
      end
      rd_pend <= do_rd;
    end
  end

  // Two-entry output queue; ob0 is always the head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ob0      <= '0;
      ob1      <= '0;
      obuf_cnt <= '0;
    end else begin
      case ({push, deq_fire})
        2'b10: begin
          if (obuf_cnt == 2'd0) ob0 <= push_data;
          else                  ob1 <= push_data;
          obuf_cnt <= obuf_cnt + 2'd1;
        end
        2'b01: begin
          ob0      <= ob1;
          obuf_cnt <= obuf_cnt - 2'd1;
        end
        2'b11: begin
          if (obuf_cnt == 2'd1) begin
            ob0 <= push_data;
          end else begin
            ob0 <= ob1;
            ob1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_array_fifo_ctrl.sv
// tb/tb_sp_array_fifo_ctrl.sv - directed bench for sp_array_fifo_ctrl with a behavioural array model
module tb_sp_array_fifo_ctrl;

`ifdef SP_ARRAY_FIFO_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 4;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enq_valid = 1'b0;
  logic       enq_ready;
  logic [6:0] enq_data = '0;
  logic       deq_valid;
  logic       deq_ready = 1'b0;
  logic [6:0] deq_data;
  logic [8:0] count;
  logic       mem_en;
  logic       mem_wmode;
  logic [7:0] mem_addr;
  logic [6:0] mem_wdata;
  logic [6:0] mem_rdata;

  always #5 clock = ~clock;

  sp_array_fifo_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count), .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port array: registered read, data valid only the cycle after.
  logic [6:0] arr [0:255];
  logic [6:0] rdata_q = '0;
  logic       rvalid_q = 1'b0;
  always @(posedge clock) begin
    rvalid_q <= mem_en && !mem_wmode;
    if (mem_en) begin
      if (mem_wmode) arr[mem_addr] <= mem_wdata;
      else           rdata_q <= arr[mem_addr];
    end
  end
  assign mem_rdata = rvalid_q ? rdata_q : 7'h2A;

  int checks = 0;
  int errors = 0;
  int q[$];
  bit occ [0:255];
  int ovr_err = 0;
  int n_enq, n_deq, n_wr, n_ops, n_er, alt_err, lat, val;
  logic last_dv, last_er, last_rd, last_fire, prev_wm, have_prev;
  logic [6:0] last_deq;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 256; i++) occ[i] = 1'b0;
  endtask

  task automatic step(input logic ev, input logic [6:0] ed, input logic dr);
    int exp;
    @(negedge clock);
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    #1;
    chk("count", int'(count), q.size());
    last_dv = deq_valid;
    last_er = enq_ready;
    last_rd = mem_en && !mem_wmode;
    if (mem_en) begin
      if (mem_wmode) begin
        if (occ[mem_addr]) ovr_err++;
        occ[mem_addr] = 1'b1;
        n_wr++;
      end else begin
        if (!occ[mem_addr]) ovr_err++;
        occ[mem_addr] = 1'b0;
      end
    end
    if (deq_valid && dr) begin
      if (q.size() == 0) begin
        chk("deq_unexpected", 1, 0);
      end else begin
        exp = q.pop_front();
        chk("deq_data", int'(deq_data), exp);
        n_deq++;
        last_deq = deq_data;
      end
    end
    last_fire = ev && enq_ready;
    if (last_fire) begin
      q.push_back(int'(ed));
      n_enq++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (q.size() != 0 || count != 0); i++) step(1'b0, 7'h00, 1'b1);
    chk("drain_count", int'(count), 0);
    chk("drain_model", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) arr[i] = 7'(i ^ 8'h3C);
    clear_model();
    n_enq = 0; n_deq = 0; n_wr = 0;

    // Reset with enq_valid held high.
    reset_n = 1'b1;
    enq_valid = 1'b1; enq_data = 7'h33; deq_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_enq_ready", int'(enq_ready), 1);
    chk("rst_deq_valid", int'(deq_valid), 0);
    chk("rst_deq_data", int'(deq_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_wmode", int'(mem_wmode), 0);
    repeat (3) @(negedge clock);
    #1;
    chk("rst_hold_count", int'(count), 0);
    chk("rst_hold_deq_valid", int'(deq_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    enq_valid = 1'b0;

    // Single entry latency.
    step(1'b1, 7'h55, 1'b1);
    chk("first_enq_fire", int'(last_fire), 1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 7'h00, 1'b1);
      if (last_dv) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, EXP_LAT);
    chk("first_value", int'(last_deq), 'h55);
    drain();

    // Fill to full with no dequeue.
    val = 0;
    for (int i = 0; i < 1500 && val < 259; i++) begin
      step(1'b1, 7'(val), 1'b0);
      if (last_fire) val++;
    end
    chk("fill_accepted", val, 259);
    repeat (5) begin
      step(1'b1, 7'(val), 1'b0);
      if (last_fire) val++;
    end
    chk("full_enq_ready", int'(last_er), 0);
    chk("full_count", int'(count), 259);
    chk("full_no_extra", val, 259);

    // Release dequeue while pushing continues.
    n_deq = 0;
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 7'(val), 1'b1);
      if (last_fire) val++;
    end
    drain();
    chk("full_stream_total", n_deq, val);

    // Random valid/ready stream of 600 values.
    n_enq = 0; n_deq = 0; n_wr = 0;
    for (int i = 0; i < 8000 && n_enq < 600; i++)
      step(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    chk("rand_accepted", n_enq, 600);
    drain();
    chk("rand_dequeued", n_deq, 600);
`ifndef SP_ARRAY_FIFO_BYPASS_EN
    chk("rand_ram_writes", n_wr, 600);
`endif

    // Reset while a read is in flight.
    for (int i = 0; i < 10; i++) step(1'b1, 7'(i + 100), 1'b0);
    last_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 7'h00, 1'b1);
      if (last_rd) break;
    end
    chk("midrst_read_seen", int'(last_rd), 1);
    @(negedge clock);
    reset_n = 1'b0;
    enq_valid = 1'b1;
    #1;
    clear_model();
    chk("midrst_count", int'(count), 0);
    chk("midrst_deq_valid", int'(deq_valid), 0);
    chk("midrst_enq_ready", int'(enq_ready), 1);
    chk("midrst_mem_en", int'(mem_en), 0);
    @(negedge clock);
    reset_n = 1'b1;
    enq_valid = 1'b0;
    n_deq = 0;
    step(1'b1, 7'h12, 1'b1);
    for (int i = 0; i < 10 && n_deq == 0; i++) step(1'b0, 7'h00, 1'b1);
    chk("postrst_deq_count", n_deq, 1);
    chk("postrst_value", int'(last_deq), 'h12);
    drain();

    // Steady stream with enq and deq always active.
    for (int i = 0; i < 20; i++) step(1'b1, 7'(i), 1'b1);
    n_er = 0; n_ops = 0; alt_err = 0; have_prev = 1'b0; prev_wm = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 7'(i + 20), 1'b1);
      if (last_er) n_er++;
      if (mem_en) begin
        n_ops++;
        if (have_prev && prev_wm == mem_wmode) alt_err++;
        prev_wm = mem_wmode;
        have_prev = 1'b1;
      end
    end
`ifdef SP_ARRAY_FIFO_BYPASS_EN
    chk("steady_enq_ready", n_er, 40);
    chk("steady_mem_ops", n_ops, 0);
`else
    chk("steady_enq_ready", n_er, 20);
    chk("steady_mem_ops", n_ops, 40);
    chk("steady_alternate", alt_err, 0);
`endif
    drain();

    chk("ram_overwrite_or_stale", ovr_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
